// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: word width, FSM states, request kinds.
package dmem_pkg;
   localparam int WORD_W = 32;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
   typedef enum logic {READ, WRITE} req_e;
endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word array, read-first, no reset; one-cycle read latency.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);
   logic [WORD_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wdata;
      rdata <= mem[idx];
   end
endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: latches a request, waits WAIT_CYCLES, then pulses memReady for one cycle.
// Optional address/dual-request checking is enabled by defining DMEM_ADDR_CHECK_EN.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic [31:0]       addr,
   input  logic [WORD_W-1:0] writeData,
   output logic [WORD_W-1:0] readData,
   output logic              memReady,
   output logic              memBusy,
   output logic              addrErr
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q;
   logic [IDX_W-1:0]  idx_q;
   logic [WORD_W-1:0] wdata_q, hold_q;
   req_e              type_q;
   logic              err_q;
   logic              mem_ready_q, mem_busy_q, addr_err_q;

   logic              req_live, err_live, cur_err, arr_we;
   req_e              type_live, cur_type;
   logic [IDX_W-1:0]  arr_idx;
   logic [WORD_W-1:0] arr_wdata, arr_rdata;

   assign req_live  = memRead | memWrite;
   assign type_live = memWrite ? WRITE : READ;

`ifdef DMEM_ADDR_CHECK_EN
   assign err_live = (addr[1:0] != 2'b00)
                  || ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS))
                  || (memRead && memWrite);
`else
   logic unused_addr;
   assign err_live    = 1'b0;
   assign unused_addr = ^{addr[31:IDX_W+2], addr[1:0]};
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_live) state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
         WAIT:    if (cnt_q == 4'd1) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // With zero wait states the commit edge is also the sampling edge, so the array sees live inputs in IDLE.
   assign arr_idx   = (state_q == IDLE) ? addr[IDX_W+1:2] : idx_q;
   assign arr_wdata = (state_q == IDLE) ? writeData : wdata_q;
   assign cur_type  = (state_q == IDLE) ? type_live : type_q;
   assign cur_err   = (state_q == IDLE) ? err_live : err_q;
   assign arr_we    = (state_d == RESP) && (state_q != RESP) && (cur_type == WRITE) && !cur_err;

   dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
      .clk   (clk),
      .we    (arr_we),
      .idx   (arr_idx),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         idx_q       <= '0;
         wdata_q     <= '0;
         type_q      <= READ;
         err_q       <= 1'b0;
         hold_q      <= '0;
         mem_ready_q <= 1'b0;
         mem_busy_q  <= 1'b0;
         addr_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_ready_q <= (state_d == RESP);
         mem_busy_q  <= (state_d != IDLE);
         addr_err_q  <= (state_d == RESP) && cur_err;
         case (state_q)
            IDLE: if (req_live) begin
               idx_q   <= addr[IDX_W+1:2];
               wdata_q <= writeData;
               type_q  <= type_live;
               err_q   <= err_live;
               cnt_q   <= WAIT_INIT;
            end
            WAIT: cnt_q <= cnt_q - 4'd1;
            RESP: if (type_q == READ && !err_q) hold_q <= arr_rdata;
            default: ;
         endcase
      end
   end

   // Load data comes straight from the array during RESP and is held afterwards.
   assign readData = (state_q == RESP && type_q == READ && !err_q) ? arr_rdata : hold_q;
   assign memReady = mem_ready_q;
   assign memBusy  = mem_busy_q;
   assign addrErr  = addr_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_dmem_responder;
   logic        clk = 1'b0;
   logic        rstN;
   logic        rd2, wr2, rdy2, busy2, err2;
   logic [31:0] a2, d2, q2;
   logic        rd0, wr0, rdy0, busy0, err0;
   logic [31:0] a0, d0, q0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_w2 (
      .clk(clk), .rstN(rstN), .memRead(rd2), .memWrite(wr2), .addr(a2), .writeData(d2),
      .readData(q2), .memReady(rdy2), .memBusy(busy2), .addrErr(err2));

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .rstN(rstN), .memRead(rd0), .memWrite(wr0), .addr(a0), .writeData(d0),
      .readData(q0), .memReady(rdy0), .memBusy(busy0), .addrErr(err0));

   // chk: 0 = ignore readData, 1 = must equal data, 2 = must differ from data
   typedef struct {
      int          chk;
      logic [31:0] data;
      logic        err;
      int          cyc;
      string       name;
   } exp_t;

   exp_t sb2[$];
   exp_t sb0[$];
   exp_t e2, e0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic score(input exp_t e, input logic [31:0] rd, input logic er);
      check32({e.name, " latency"}, 32'(cyc), 32'(e.cyc));
      check32({e.name, " addrErr"}, {31'd0, er}, {31'd0, e.err});
      if (e.chk == 1) check32({e.name, " readData"}, rd, e.data);
      else if (e.chk == 2) begin
         n_cmp++;
         if (rd === e.data) begin
            n_bad++;
            $display("FAIL %s readData: got %h expected anything else", e.name, rd);
         end
      end
   endtask

   always @(negedge clk) begin
      if (rstN && rdy2) begin
         if (sb2.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL w2 unexpected memReady: got 1 expected 0");
         end else begin
            e2 = sb2.pop_front();
            score(e2, q2, err2);
         end
      end
   end

   always @(negedge clk) begin
      if (rstN && rdy0) begin
         if (sb0.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL w0 unexpected memReady: got 1 expected 0");
         end else begin
            e0 = sb0.pop_front();
            score(e0, q0, err0);
         end
      end
   end

   task automatic wait_ready(input bit sel0, input string nm);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(sel0 ? rdy0 : rdy2) && n < 40);
      n_cmp++;
      if (!(sel0 ? rdy0 : rdy2)) begin
         n_bad++;
         $display("FAIL %s timeout: memReady got 0 expected 1 within 40 cycles", nm);
      end
   endtask

   task automatic access(input bit sel0, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input int chk, input logic [31:0] xd,
                         input logic xe, input string nm);
      exp_t e;
      @(negedge clk);
      e.chk = chk; e.data = xd; e.err = xe; e.name = nm;
      e.cyc = cyc + (sel0 ? 1 : 3);
      if (sel0) begin
         sb0.push_back(e);
         rd0 = rd; wr0 = wr; a0 = a; d0 = d;
      end else begin
         sb2.push_back(e);
         rd2 = rd; wr2 = wr; a2 = a; d2 = d;
      end
      wait_ready(sel0, nm);
      rd0 = 1'b0; wr0 = 1'b0; rd2 = 1'b0; wr2 = 1'b0;
   endtask

   task automatic summary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
   endtask

   initial begin
      exp_t e;
      rstN = 1'b0;
      rd2 = 0; wr2 = 0; a2 = 0; d2 = 0;
      rd0 = 0; wr0 = 0; a0 = 0; d0 = 0;
      repeat (2) @(negedge clk);
      check32("reset readData", q2, 32'h0);
      check32("reset memReady", {31'd0, rdy2}, 32'd0);
      check32("reset memBusy", {31'd0, busy2}, 32'd0);
      check32("reset addrErr", {31'd0, err2}, 32'd0);
      check32("reset w0 readData", q0, 32'h0);
      rstN = 1'b1;

      // store aborted by reset while in WAIT
      @(negedge clk);
      wr2 = 1'b1; a2 = 32'h18; d2 = 32'h1234_5678;
      @(negedge clk);
      check32("mid busy before reset", {31'd0, busy2}, 32'd1);
      rstN = 1'b0;
      #1;
      check32("mid reset readData", q2, 32'h0);
      check32("mid reset memReady", {31'd0, rdy2}, 32'd0);
      check32("mid reset memBusy", {31'd0, busy2}, 32'd0);
      check32("mid reset addrErr", {31'd0, err2}, 32'd0);
      wr2 = 1'b0;
      @(negedge clk);
      rstN = 1'b1;
      access(0, 1, 0, 32'h18, 32'h0, 2, 32'h1234_5678, 1'b0, "load 0x18 after abort");

      access(0, 0, 1, 32'h40, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, "store 0x40");
      access(0, 1, 0, 32'h40, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, "load 0x40");
      access(0, 0, 1, 32'h0, 32'h1111_1111, 0, 32'h0, 1'b0, "store 0x0");
      access(0, 0, 1, 32'h4, 32'h2222_2222, 0, 32'h0, 1'b0, "store 0x4");

      // back-to-back loads with memRead held high
      @(negedge clk);
      e.chk = 1; e.err = 1'b0;
      e.data = 32'h1111_1111; e.cyc = cyc + 3; e.name = "b2b load 0x0";
      sb2.push_back(e);
      e.data = 32'h2222_2222; e.cyc = cyc + 7; e.name = "b2b load 0x4";
      sb2.push_back(e);
      rd2 = 1'b1; a2 = 32'h0;
      wait_ready(0, "b2b first");
      a2 = 32'h4;
      @(negedge clk);
      check32("b2b idle gap memBusy", {31'd0, busy2}, 32'd0);
      @(negedge clk);
      check32("b2b second memBusy", {31'd0, busy2}, 32'd1);
      wait_ready(0, "b2b second");
      rd2 = 1'b0;

`ifdef DMEM_ADDR_CHECK_EN
      access(0, 0, 1, 32'h42, 32'h0BAD_F00D, 0, 32'h0, 1'b1, "misaligned store 0x42");
      access(0, 1, 0, 32'h40, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, "load 0x40 after bad store");
      access(0, 1, 0, 32'h400, 32'h0, 1, 32'hDEAD_BEEF, 1'b1, "out-of-range load 0x400");
      access(0, 1, 1, 32'h40, 32'h0, 0, 32'h0, 1'b1, "dual request 0x40");
      access(0, 1, 0, 32'h40, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, "load 0x40 after dual");
`else
      access(0, 0, 1, 32'h404, 32'hA5A5_A5A5, 0, 32'h0, 1'b0, "wrap store 0x404");
      access(0, 1, 0, 32'h4, 32'h0, 1, 32'hA5A5_A5A5, 1'b0, "wrap load 0x4");
`endif

      access(1, 0, 1, 32'h8, 32'hCAFE_F00D, 0, 32'h0, 1'b0, "w0 store 0x8");
      access(1, 1, 0, 32'h8, 32'h0, 1, 32'hCAFE_F00D, 1'b0, "w0 load 0x8");

      repeat (4) @(negedge clk);
      check32("w2 scoreboard drained", 32'(sb2.size()), 32'd0);
      check32("w0 scoreboard drained", 32'(sb0.size()), 32'd0);
      summary();
      $finish;
   end

   initial begin
      #100000;
      n_bad++;
      $display("FAIL watchdog: simulation got stuck, expected completion");
      summary();
      $fatal(1, "watchdog expired");
   end
endmodule
